// File: rtl/stage_seq_arbiter_pkg.sv
// Shared types and helpers for the stage sequencing arbiter.
//   state_e  : FSM state encodings (2 bits)
//   id_width : width of a requester index for n requesters (minimum 1)
package stage_seq_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN_A = 2'd1,
        ST_RUN_B = 2'd2,
        ST_RUN_C = 2'd3
    } state_e;

    function automatic int unsigned id_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/stage_seq_arbiter_rr_arbiter.sv
// Purely combinational round-robin pick.
//   req      : request vector
//   ptr      : index with highest priority this round
//   winner_c : one-hot winner (0 when no request)
//   idx_c    : index of the winner
//   any_c    : at least one request present
module rr_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] winner_c,
    output logic [IDW-1:0]  idx_c,
    output logic            any_c
);

    logic [IDW-1:0] cidx;

    // Scan from ptr upward, wrapping NREQ-1 -> 0; first requester wins.
    always_comb begin
        winner_c = '0;
        idx_c    = '0;
        any_c    = 1'b0;
        cidx     = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cidx = IDW'((32'(ptr) + i) % NREQ);
            if (!any_c && req[cidx]) begin
                any_c          = 1'b1;
                winner_c[cidx] = 1'b1;
                idx_c          = cidx;
            end
        end
    end

endmodule

// File: rtl/stage_seq_arbiter.sv
// Shares one A->B->C stage engine among NREQ requesters: round-robin grant,
// stage sequencing and a per-stage watchdog.
//   clk, reset (async, active-low)
//   req[NREQ]              level requests
//   gnt[NREQ], busy        one-hot owner for the whole job, job in progress
//   start_a/b/c            one-cycle stage launch pulses
//   done_a/b/c             one-cycle stage completion pulses
//   done, err, done_id     job completion / watchdog abort with owner index
module stage_seq_arbiter
    import stage_seq_arbiter_pkg::*;
#(
    parameter  int unsigned NREQ    = 4,
    parameter  int unsigned TIMEOUT = 255,
    parameter  int unsigned TW      = 8,
    localparam int unsigned IDW     = id_width(NREQ)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic            busy,
    output logic            start_a,
    output logic            start_b,
    output logic            start_c,
    input  logic            done_a,
    input  logic            done_b,
    input  logic            done_c,
    output logic            done,
    output logic            err,
    output logic [IDW-1:0]  done_id
);

    state_e          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            busy_q, busy_d;
    logic            start_a_q, start_a_d;
    logic            start_b_q, start_b_d;
    logic            start_c_q, start_c_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [IDW-1:0]  done_id_q, done_id_d;
    logic [IDW-1:0]  owner_q, owner_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [TW-1:0]   timer_q, timer_d;

    logic [NREQ-1:0] winner_c;
    logic [IDW-1:0]  idx_c;
    logic            any_c;
    logic            stage_done_c;
    logic            expired_c;
    logic [IDW-1:0]  ptr_next_c;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr (
        .req      (req),
        .ptr      (ptr_q),
        .winner_c (winner_c),
        .idx_c    (idx_c),
        .any_c    (any_c)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        timer_d   = timer_q;
        done_id_d = done_id_q;
        start_a_d = 1'b0;
        start_b_d = 1'b0;
        start_c_d = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;

        // Only the done of the stage currently running counts.
        unique case (state_q)
            ST_RUN_A: stage_done_c = done_a;
            ST_RUN_B: stage_done_c = done_b;
            ST_RUN_C: stage_done_c = done_c;
            default:  stage_done_c = 1'b0;
        endcase

        expired_c  = (TIMEOUT != 0) && (timer_q == TW'(TIMEOUT));
        ptr_next_c = (owner_q == IDW'(NREQ - 1)) ? '0 : owner_q + IDW'(1);

        if (state_q == ST_IDLE) begin
            if (any_c) begin
                gnt_d     = winner_c;
                owner_d   = idx_c;
                start_a_d = 1'b1;
                timer_d   = '0;
                state_d   = ST_RUN_A;
            end
        end else if (stage_done_c) begin
            // A matching done beats a simultaneous watchdog expiry.
            timer_d = '0;
            unique case (state_q)
                ST_RUN_A: begin
                    start_b_d = 1'b1;
                    state_d   = ST_RUN_B;
                end
                ST_RUN_B: begin
                    start_c_d = 1'b1;
                    state_d   = ST_RUN_C;
                end
                default: begin
                    done_d    = 1'b1;
                    done_id_d = owner_q;
                    gnt_d     = '0;
                    ptr_d     = ptr_next_c;
                    state_d   = ST_IDLE;
                end
            endcase
        end else if (expired_c) begin
            err_d     = 1'b1;
            done_id_d = owner_q;
            gnt_d     = '0;
            ptr_d     = ptr_next_c;
            state_d   = ST_IDLE;
        end else begin
            timer_d = timer_q + TW'(1);
        end

        busy_d = |gnt_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            busy_q    <= 1'b0;
            start_a_q <= 1'b0;
            start_b_q <= 1'b0;
            start_c_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            done_id_q <= '0;
            owner_q   <= '0;
            ptr_q     <= '0;
            timer_q   <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            busy_q    <= busy_d;
            start_a_q <= start_a_d;
            start_b_q <= start_b_d;
            start_c_q <= start_c_d;
            done_q    <= done_d;
            err_q     <= err_d;
            done_id_q <= done_id_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            timer_q   <= timer_d;
        end
    end

    assign gnt     = gnt_q;
    assign busy    = busy_q;
    assign start_a = start_a_q;
    assign start_b = start_b_q;
    assign start_c = start_c_q;
    assign done    = done_q;
    assign err     = err_q;
    assign done_id = done_id_q;

endmodule
